// File: rtl/write_combine_buffer_if.sv
// write_combine_buffer_if: CPU word-write port and memory line-write port of the write-combining buffer.
interface write_combine_buffer_if #(
    parameter int WORD_W = 16,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
);
    logic                  cpu_write;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [WORD_W-1:0]     cpu_wdata;
    logic [WORD_W/8-1:0]   cpu_byte_enable;
    logic                  cpu_resp;
    logic                  flush;
    logic                  flush_done;
    logic                  mem_write;
    logic [ADDR_W-1:0]     mem_addr;
    logic [LINE_W-1:0]     mem_wdata;
    logic [LINE_W/8-1:0]   mem_byte_mask;
    logic                  mem_resp;

    modport slave (
        input  cpu_write, cpu_addr, cpu_wdata, cpu_byte_enable, flush, mem_resp,
        output cpu_resp, flush_done, mem_write, mem_addr, mem_wdata, mem_byte_mask
    );

    modport master (
        output cpu_write, cpu_addr, cpu_wdata, cpu_byte_enable, flush, mem_resp,
        input  cpu_resp, flush_done, mem_write, mem_addr, mem_wdata, mem_byte_mask
    );
endinterface

// File: rtl/write_combine_buffer.sv
// write_combine_buffer: merges CPU word writes into one line and drains it on conflict or flush.
// Define WCB_AUTO_DRAIN_EN to drain automatically once every byte of the line is written.
module write_combine_buffer #(
    parameter int WORD_W = 16,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
) (
    input logic clk,
    input logic reset_n,
    write_combine_buffer_if.slave bus
);
    localparam int WB    = WORD_W / 8;
    localparam int LB    = LINE_W / 8;
    localparam int OFF_W = $clog2(LB);
    localparam int BW    = $clog2(WB);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t                  state;
    logic [ADDR_W-OFF_W-1:0] tag;
    logic [ADDR_W-OFF_W-1:0] addr_tag;
    logic [LB-1:0]           mask;
    logic [LB-1:0]           next_mask;
    logic [LINE_W-1:0]       data;
    logic [LINE_W-1:0]       next_data;
    logic [OFF_W-1:0]        slot;
    logic                    mem_write;
    logic                    flush_done;
    logic                    accept;
    logic                    load;
    logic                    conflict;
    logic                    full;

    assign addr_tag = bus.cpu_addr[ADDR_W-1:OFF_W];
    assign slot     = bus.cpu_addr[OFF_W-1:0] >> BW;
    assign accept   = reset_n && bus.cpu_write && (state == IDLE || (state == COLLECT && addr_tag == tag));
    assign load     = accept && |bus.cpu_byte_enable;
    assign conflict = bus.cpu_write && addr_tag != tag;

`ifdef WCB_AUTO_DRAIN_EN
    assign full = &mask;
`else
    assign full = 1'b0;
`endif

    // Data bytes are only ever written alongside their mask bit, so unwritten bytes stay 0.
    always_comb begin
        next_mask = mask;
        next_data = data;
        for (int j = 0; j < LB; j++)
            if (accept && slot == OFF_W'(j / WB) && bus.cpu_byte_enable[j % WB]) begin
                next_mask[j]        = 1'b1;
                next_data[j*8 +: 8] = bus.cpu_wdata[(j % WB)*8 +: 8];
            end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state      <= IDLE;
            tag        <= '0;
            mask       <= '0;
            data       <= '0;
            mem_write  <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= state == IDLE && bus.flush && !load;
            mask       <= next_mask;
            data       <= next_data;
            case (state)
                IDLE:
                    if (load) begin
                        tag   <= addr_tag;
                        state <= COLLECT;
                    end
                COLLECT:
                    if (conflict || bus.flush || full) begin
                        state     <= DRAIN;
                        mem_write <= 1'b1;
                    end
                DRAIN:
                    if (bus.mem_resp) begin
                        state     <= IDLE;
                        mem_write <= 1'b0;
                        mask      <= '0;
                        data      <= '0;
                    end
                default: state <= IDLE;
            endcase
        end

    assign bus.cpu_resp      = accept;
    assign bus.flush_done    = flush_done;
    assign bus.mem_write     = mem_write;
    assign bus.mem_addr      = {tag, {OFF_W{1'b0}}};
    assign bus.mem_wdata     = data;
    assign bus.mem_byte_mask = mask;
endmodule

// File: doc/write_combine_buffer.md
WRITE_COMBINE_BUFFER -- requirements
Module: write_combine_buffer

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16, giving the CPU write word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter LINE_W, default 128, giving the line width in bits (power-of-two multiple of WORD_W).
REQ-003 The block SHALL have parameter ADDR_W, default 16, giving the byte address width; OFF_W = log2(LINE_W/8).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port cpu_write, input, 1 bit: write request, held until cpu_resp.
REQ-007 The block SHALL have port cpu_addr, input, ADDR_W bits: byte address, word-aligned.
REQ-008 The block SHALL have port cpu_wdata, input, WORD_W bits: write data.
REQ-009 The block SHALL have port cpu_byte_enable, input, WORD_W/8 bits: per-byte write enable.
REQ-010 The block SHALL have port cpu_resp, output, 1 bit: write accepted this cycle.
REQ-011 The block SHALL have port flush, input, 1 bit: drain request, level-sensitive.
REQ-012 The block SHALL have port flush_done, output, 1 bit: one-cycle pulse when the buffer is empty after a flush.
REQ-013 The block SHALL have port mem_write, output, 1 bit: line write request, held until mem_resp.
REQ-014 The block SHALL have port mem_addr, output, ADDR_W bits: {tag, OFF_W zeros}.
REQ-015 The block SHALL have port mem_wdata, output, LINE_W bits: merged line data, with unwritten bytes driven 0.
REQ-016 The block SHALL have port mem_byte_mask, output, LINE_W/8 bits: bytes valid in mem_wdata.
REQ-017 The block SHALL have port mem_resp, input, 1 bit: memory accepted the line.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE (mask all 0), COLLECT (tag valid, mask nonzero), DRAIN (mem_write=1).
REQ-019 cpu_resp SHALL be combinational: 1 when cpu_write=1 and (state=IDLE, or state=COLLECT with cpu_addr[ADDR_W-1:OFF_W]==tag); otherwise 0.
REQ-020 On acceptance, word slot cpu_addr[OFF_W-1:log2(WORD_W/8)] byte i SHALL take cpu_wdata byte i and set its mask bit iff cpu_byte_enable[i]=1; bytes with enable 0 SHALL be unchanged.
REQ-021 An IDLE acceptance with nonzero enables SHALL load the tag and go to COLLECT; all-zero enables SHALL respond and remain in IDLE.
REQ-022 In COLLECT, a cpu_write to a different tag SHALL get cpu_resp=0 and force DRAIN; the write SHALL be accepted in IDLE after the drain completes.
REQ-023 flush=1 in COLLECT SHALL go to DRAIN; flush=1 in IDLE SHALL pulse flush_done on the next cycle.
REQ-024 Same-tag write together with flush in COLLECT SHALL merge the write (cpu_resp=1) and then enter DRAIN with the merged line.
REQ-025 In DRAIN, mem_write SHALL stay 1 and mem_addr/mem_wdata/mem_byte_mask SHALL be stable until mem_resp, and cpu_resp SHALL be 0.
REQ-026 On mem_resp in DRAIN, the mask SHALL clear and the state SHALL go to IDLE next cycle; if flush is still 1 in that cycle, flush_done SHALL pulse in the cycle after IDLE is reached.
REQ-027 mem_resp outside DRAIN SHALL be ignored.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, mask=0, tag=0, data=0, mem_write=0, and flush_done=0, including mid-DRAIN (the line is discarded).
REQ-029 cpu_resp SHALL be 0 while reset_n=0.

Configuration
REQ-030 With WCB_AUTO_DRAIN_EN defined, COLLECT SHALL enter DRAIN the cycle after the mask becomes all 1s.
REQ-031 Without WCB_AUTO_DRAIN_EN, a full line SHALL stay in COLLECT until a conflicting write or flush arrives.

Verification
REQ-032 Reset, then write addr 0x1002, data 0xBEEF, be=11, then flush, then mem_resp -> cpu_resp=1 the same cycle; mem_addr=0x1000; mem_byte_mask=0x000C; mem_wdata[31:16]=0xBEEF; flush_done pulses after IDLE.
REQ-033 Write 0x2000 data 0x1234 be=01, then 0x2000 data 0xAB00 be=10, then flush -> mem_wdata[15:0]=0xAB34, mask=0x0003.
REQ-034 Write 0x3000, then write 0x4000 -> the second write stalls and mem_addr=0x3000; after mem_resp the second write is accepted and the tag is 0x400.
REQ-035 Eight be=11 writes to 0x5000-0x500E -> with the macro, DRAIN with mask=0xFFFF without flush; without the macro, stay in COLLECT.
REQ-036 Assert reset_n=0 mid-DRAIN, then release -> mem_write=0 immediately, state IDLE; a subsequent flush pulses flush_done with no mem_write.
REQ-037 Write with be=00 to 0x6000 in IDLE -> cpu_resp=1, state stays IDLE; a flush gives flush_done and no mem_write.
